// File: rtl/dbs_if.sv
// dbs_if: operand/result bundle for the dbs sequential divider.
//   master : drives start, dividendo, divisor; observes results
//   slave  : the divider itself
// Signals:
//   start      request, sampled only while the divider is idle
//   dividendo  unsigned dividend  (LARGURA bits)
//   divisor    unsigned divisor   (LARGURA bits)
//   quociente  registered quotient (LARGURA bits)
//   resto      registered remainder (LARGURA bits)
//   pronto     one-cycle result-valid pulse
//   ocupado    high while iterating
//   div_zero   result came from a zero divisor
interface dbs_if #(
  parameter int unsigned LARGURA = 8
);
  logic               start;
  logic [LARGURA-1:0] dividendo;
  logic [LARGURA-1:0] divisor;
  logic [LARGURA-1:0] quociente;
  logic [LARGURA-1:0] resto;
  logic               pronto;
  logic               ocupado;
  logic               div_zero;

  modport master (
    output start, dividendo, divisor,
    input  quociente, resto, pronto, ocupado, div_zero
  );

  modport slave (
    input  start, dividendo, divisor,
    output quociente, resto, pronto, ocupado, div_zero
  );
endinterface

// File: rtl/dbs.sv
// dbs: sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous, active-high
//   bus    dbs_if slave modport (start/operands in, quotient/remainder/status out)
// A start in the idle state latches the operands; LARGURA iterations later the
// result is loaded and pronto pulses for one cycle. A zero divisor skips the
// iterations and reports all-ones quotient, remainder = dividend, div_zero = 1.
module dbs #(
  parameter int unsigned LARGURA = 8
) (
  input logic  clock,
  input logic  reset,
  dbs_if.slave bus
);

  localparam int unsigned CW = $clog2(LARGURA + 1);

  typedef enum logic [1:0] {Ocioso, Calcula, Fim} estado_t;

  estado_t            estado_atual, estado_prox;
  logic [LARGURA-1:0] reg_quo, reg_quo_prox;   // dividend shifting out, quotient shifting in
  logic [LARGURA-1:0] reg_div, reg_div_prox;   // latched divisor
  logic [LARGURA-1:0] reg_res, reg_res_prox;   // partial remainder
  logic [CW-1:0]      contador, contador_prox;
  logic [LARGURA-1:0] quociente_prox, resto_prox;
  logic               pronto_prox, ocupado_prox, div_zero_prox;

  // One restoring step. The shifted remainder can reach 2*divisor-1, so the
  // trial compare is done one bit wider than the operands.
  logic [LARGURA:0]   r_desl;
  logic               cabe;
  logic [LARGURA-1:0] q_iter, r_iter;

  always_comb begin
    r_desl = {reg_res, reg_quo[LARGURA-1]};
    cabe   = (r_desl >= {1'b0, reg_div});
    q_iter = {reg_quo[LARGURA-2:0], cabe};
    r_iter = cabe ? LARGURA'(r_desl - {1'b0, reg_div}) : r_desl[LARGURA-1:0];
  end

  always_comb begin
    estado_prox    = estado_atual;
    reg_quo_prox   = reg_quo;
    reg_div_prox   = reg_div;
    reg_res_prox   = reg_res;
    contador_prox  = contador;
    quociente_prox = bus.quociente;
    resto_prox     = bus.resto;
    pronto_prox    = 1'b0;
    ocupado_prox   = bus.ocupado;
    div_zero_prox  = bus.div_zero;

    unique case (estado_atual)
      Ocioso: begin
        if (bus.start) begin
          reg_quo_prox  = bus.dividendo;
          reg_div_prox  = bus.divisor;
          reg_res_prox  = '0;
          contador_prox = CW'(LARGURA);
          div_zero_prox = 1'b0;
          if (bus.divisor != '0) begin
            estado_prox  = Calcula;
            ocupado_prox = 1'b1;
          end else begin
            estado_prox    = Fim;
            quociente_prox = '1;
            resto_prox     = bus.dividendo;
            div_zero_prox  = 1'b1;
            pronto_prox    = 1'b1;
          end
        end
      end
      Calcula: begin
        reg_quo_prox  = q_iter;
        reg_res_prox  = r_iter;
        contador_prox = contador - CW'(1);
        if (contador == CW'(1)) begin
          quociente_prox = q_iter;
          resto_prox     = r_iter;
          pronto_prox    = 1'b1;
          ocupado_prox   = 1'b0;
          estado_prox    = Fim;
        end
      end
      Fim: begin
        estado_prox = Ocioso;
      end
      default: begin
        estado_prox  = Ocioso;
        ocupado_prox = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_atual  <= Ocioso;
      reg_quo       <= '0;
      reg_div       <= '0;
      reg_res       <= '0;
      contador      <= '0;
      bus.quociente <= '0;
      bus.resto     <= '0;
      bus.pronto    <= 1'b0;
      bus.ocupado   <= 1'b0;
      bus.div_zero  <= 1'b0;
    end else begin
      estado_atual  <= estado_prox;
      reg_quo       <= reg_quo_prox;
      reg_div       <= reg_div_prox;
      reg_res       <= reg_res_prox;
      contador      <= contador_prox;
      bus.quociente <= quociente_prox;
      bus.resto     <= resto_prox;
      bus.pronto    <= pronto_prox;
      bus.ocupado   <= ocupado_prox;
      bus.div_zero  <= div_zero_prox;
    end
  end

endmodule

// File: tb/tb_dbs.sv
// tb_dbs: scoreboard bench for the dbs divider. Stimulus pushes the expected
// {quociente, resto, div_zero} per accepted start; a negedge monitor pops and
// compares whenever pronto is high. Stimulus also checks latency and ocupado.
module tb_dbs;
  localparam int unsigned L = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dbs_if #(.LARGURA(L)) bus ();

  dbs #(.LARGURA(L)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [L-1:0] q;
    logic [L-1:0] r;
    logic         dz;
  } res_t;

  res_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic pronto_ant = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare every result pulse against the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.pronto) begin
        check("pronto_one_cycle", int'(pronto_ant), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_pronto", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("quociente", int'(bus.quociente), int'(e.q));
          check("resto", int'(bus.resto), int'(e.r));
          check("div_zero", int'(bus.div_zero), int'(e.dz));
        end
      end
      pronto_ant = bus.pronto;
    end else begin
      pronto_ant = 1'b0;
    end
  end

  // One operation. hold=1 keeps start high and swaps operands to 1/1 while
  // the divider is busy, then holds start through the FIM edge.
  task automatic run_op(input logic [L-1:0] a, input logic [L-1:0] b,
                        input logic [L-1:0] eq, input logic [L-1:0] er,
                        input bit hold);
    int  lat;
    int  k;
    bit  seen;
    lat  = (b == 0) ? 0 : int'(L);
    seen = 1'b0;
    k    = 0;
    @(negedge clock);
    bus.start     = 1'b1;
    bus.dividendo = a;
    bus.divisor   = b;
    exp_q.push_back('{q: eq, r: er, dz: (b == 0)});
    @(posedge clock);
    #1;
    if (hold) begin
      bus.dividendo = 1;
      bus.divisor   = 1;
    end else begin
      bus.start = 1'b0;
    end
    while (!seen && k <= int'(L) + 2) begin
      @(negedge clock);
      if (bus.pronto) begin
        seen = 1'b1;
        check("latency", k, lat);
        check("ocupado_at_pronto", int'(bus.ocupado), 0);
      end else begin
        check("ocupado_busy", int'(bus.ocupado), 1);
        k++;
      end
    end
    if (!seen) check("pronto_timeout", 0, 1);
    @(posedge clock);
    if (hold) begin
      @(negedge clock);
      bus.start = 1'b0;
      check("start_ignored_in_fim", int'(bus.ocupado), 0);
      check("no_second_pronto", int'(bus.pronto), 0);
    end
  endtask

  initial begin
    logic [L-1:0] a;
    logic [L-1:0] b;
    bus.start     = 1'b0;
    bus.dividendo = '0;
    bus.divisor   = '0;
    #12;
    check("rst_quociente", int'(bus.quociente), 0);
    check("rst_resto", int'(bus.resto), 0);
    check("rst_pronto", int'(bus.pronto), 0);
    check("rst_ocupado", int'(bus.ocupado), 0);
    check("rst_div_zero", int'(bus.div_zero), 0);
    @(negedge clock);
    reset = 1'b0;

    run_op(8'd120, 8'd96,  8'd1,   8'd24, 1'b0);
    run_op(8'd200, 8'd13,  8'd15,  8'd5,  1'b0);
    run_op(8'd96,  8'd120, 8'd0,   8'd96, 1'b0);
    run_op(8'd255, 8'd1,   8'd255, 8'd0,  1'b0);
    run_op(8'd255, 8'd255, 8'd1,   8'd0,  1'b0);
    run_op(8'd7,   8'd0,   8'd255, 8'd7,  1'b0);
    run_op(8'd9,   8'd3,   8'd3,   8'd0,  1'b0);

    // Abort mid-operation with reset.
    @(negedge clock);
    bus.start     = 1'b1;
    bus.dividendo = 8'd200;
    bus.divisor   = 8'd13;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_quociente", int'(bus.quociente), 0);
    check("abort_resto", int'(bus.resto), 0);
    check("abort_pronto", int'(bus.pronto), 0);
    check("abort_ocupado", int'(bus.ocupado), 0);
    check("abort_div_zero", int'(bus.div_zero), 0);
    @(negedge clock);
    reset = 1'b0;
    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

    // Operand change and held start while busy.
    run_op(8'd50, 8'd7, 8'd7, 8'd1, 1'b1);

    // Back-to-back pseudo-random operands against a / and % reference.
    for (int i = 0; i < 40; i++) begin
      a = L'($urandom_range(0, 255));
      b = L'($urandom_range(0, 255));
      if (i % 13 == 0) b = '0;
      if (b == 0) run_op(a, b, '1, a, 1'b0);
      else        run_op(a, b, a / b, a % b, 1'b0);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
